// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
//   - FSM state encoding for imem_loader
//   - stream framing constants (header length, checksum width)
//   - CPU reset levels, matching the core's RstEnable/RstDisable encoding
//   - accepts_byte(): which states take a byte from the stream
package imem_loader_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_HDR_HI = 3'd0;
    localparam logic [STATE_W-1:0] ST_HDR_LO = 3'd1;
    localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
    localparam logic [STATE_W-1:0] ST_WRITE  = 3'd3;
    localparam logic [STATE_W-1:0] ST_CSUM   = 3'd4;
    localparam logic [STATE_W-1:0] ST_RUN    = 3'd5;
    localparam logic [STATE_W-1:0] ST_ERR    = 3'd6;

    localparam int HDR_BYTES = 2;
    localparam int CSUM_W    = 8;

    // CPU reset is active-high on the core side
    localparam logic RST_ENABLE  = 1'b1;
    localparam logic RST_DISABLE = 1'b0;

    function automatic logic accepts_byte(input logic [STATE_W-1:0] st);
        return (st == ST_HDR_HI) || (st == ST_HDR_LO) ||
               (st == ST_DATA)   || (st == ST_CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
//   in_valid/in_data/in_ready : byte stream, transfer when in_valid && in_ready
//   mem_we/mem_addr/mem_wdata : one-cycle word write strobe into instruction memory
// Modports:
//   master : byte source / memory side (drives the stream, observes writes)
//   slave  : the loader itself
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/imem_loader_word_packer.sv
// Byte-to-word packer for the instruction-memory loader.
// Ports:
//   clk, rst     : clock, synchronous active-low reset
//   clear        : synchronous restart (index and checksum back to zero)
//   shift_en     : accept byte_in as the next big-endian byte of the word
//   byte_in      : incoming data byte
//   word_out     : three buffered bytes with byte_in appended (the full word
//                  when the 4th byte is being accepted)
//   idx          : position of the next byte within the word (0..3)
//   xor_acc      : running XOR of all accepted data bytes
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [7:0]        byte_in,
    output logic [31:0]       word_out,
    output logic [1:0]        idx,
    output logic [CSUM_W-1:0] xor_acc
);

    // Only three bytes need buffering; the fourth is taken straight from the
    // input on the cycle it is accepted.
    logic [23:0] shreg;

    assign word_out = {shreg, byte_in};

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            idx     <= 2'd0;
            xor_acc <= '0;
        end else if (shift_en) begin
            idx     <= idx + 2'd1;
            xor_acc <= xor_acc ^ byte_in;
        end
    end

    always_ff @(posedge clk) begin
        if (shift_en) begin
            shreg <= {shreg[15:0], byte_in};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer.
// Receives {count_hi, count_lo, N x 4 data bytes, checksum} on a byte stream,
// writes each packed big-endian word to instruction memory, and releases the
// CPU from reset only once the checksum verifies.
// Ports:
//   clk, rst      : clock, synchronous active-low reset
//   bus           : byte stream in + memory write port (slave modport)
//   load_req      : one-cycle pulse, abort and restart the load
//   cpu_rst       : CPU reset, 1 = held in reset
//   done          : image loaded and verified, CPU running
//   err           : oversize count or checksum mismatch
//   words_loaded  : words written during the current load
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    imem_loader_if.slave      bus,
    input  logic              load_req,
    output logic              cpu_rst,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [31:0] DEPTH = 32'(1) << ADDR_W;

    logic [STATE_W-1:0] state;
    logic [15:0]        word_cnt;
    logic               accept;
    logic [15:0]        hdr_n;
    logic [ADDR_W:0]    wl_next;
    logic [31:0]        word_asm;
    logic [1:0]         byte_idx;
    logic [CSUM_W-1:0]  xor_acc;

    assign bus.in_ready = accepts_byte(state);

    // A restart in the same cycle drops the byte on the bus
    assign accept  = bus.in_valid && bus.in_ready && !load_req;
    assign hdr_n   = {word_cnt[15:8], bus.in_data};
    assign wl_next = words_loaded + 1'b1;

    imem_word_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .clear    (load_req),
        .shift_en (accept && (state == ST_DATA)),
        .byte_in  (bus.in_data),
        .word_out (word_asm),
        .idx      (byte_idx),
        .xor_acc  (xor_acc)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ST_HDR_HI;
            word_cnt      <= '0;
            words_loaded  <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            cpu_rst       <= RST_ENABLE;
            done          <= 1'b0;
            err           <= 1'b0;
        end else if (load_req) begin
            state        <= ST_HDR_HI;
            words_loaded <= '0;
            bus.mem_we   <= 1'b0;
            cpu_rst      <= RST_ENABLE;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            bus.mem_we <= 1'b0;
            case (state)
                ST_HDR_HI: begin
                    if (accept) begin
                        word_cnt[15:8] <= bus.in_data;
                        state          <= ST_HDR_LO;
                    end
                end
                ST_HDR_LO: begin
                    if (accept) begin
                        word_cnt[7:0] <= bus.in_data;
                        if (32'(hdr_n) > DEPTH) begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end else if (hdr_n == 16'd0) begin
                            state <= ST_CSUM;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    // Write strobe is registered so it lands in the WRITE cycle
                    if (accept && (byte_idx == 2'd3)) begin
                        state         <= ST_WRITE;
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= words_loaded[ADDR_W-1:0];
                        bus.mem_wdata <= word_asm;
                    end
                end
                ST_WRITE: begin
                    words_loaded <= wl_next;
                    if (32'(wl_next) == 32'(word_cnt)) begin
                        state <= ST_CSUM;
                    end else begin
                        state <= ST_DATA;
                    end
                end
                ST_CSUM: begin
                    if (accept) begin
                        if ((xor_acc ^ bus.in_data) == '0) begin
                            state   <= ST_RUN;
                            cpu_rst <= RST_DISABLE;
                            done    <= 1'b1;
                        end else begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                default: begin
                    // RUN and ERR hold until load_req or reset
                end
            endcase
        end
    end

endmodule
